keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner, the successor to the fixed 4x4 hex decoder. Drives active-low columns in rotation and samples synchronised active-low rows. Debounces whole scan frames and reports press/release events through a valid/ready handshake, plus a held-key level and a multi-key flag. Sits between the board keypad pins and game/control logic.

---
 rtl/keypad_pkg.sv | 17 +
 rtl/sync_2ff.sv | 21 ++
 rtl/keypad_scanner.sv | 121 ++++++++++++
 tb/tb_keypad_scanner.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the keypad scanner.
package keypad_pkg;
  typedef enum logic [1:0] {PC_NONE, PC_ONE, PC_MULTI} pop_class_e;
  localparam logic EVT_PRESS = 1'b0;
  localparam logic EVT_RELEASE = 1'b1;
  localparam int MAX_KEYS = 256;
  function automatic pop_class_e pop_class(input logic [MAX_KEYS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < MAX_KEYS; i++) n += int'(v[i]);
    return n == 0 ? PC_NONE : n == 1 ? PC_ONE : PC_MULTI;
  endfunction
  function automatic int unsigned onehot_idx(input logic [MAX_KEYS-1:0] v);
    onehot_idx = 0;
    for (int unsigned i = 0; i < MAX_KEYS; i++) if (v[i]) onehot_idx = i;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser with a configurable reset value.
module sync_2ff #(
  parameter int W = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-rotating matrix keypad scanner with frame debounce
// and press/release events over a valid/ready handshake.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int NUM_COLS = 4,
  parameter int NUM_ROWS = 4,
  parameter int COL_DWELL = 100000,
  parameter int COL_SETTLE = 8,
  parameter int DEBOUNCE_FRAMES = 3,
  localparam int IDX_W = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [IDX_W-1:0]    evt_index,
  output logic                evt_release,
  output logic                key_held,
  output logic [IDX_W-1:0]    held_index,
  output logic                multi_key,
  output logic                overflow,
  input  logic                ovf_clr
);
  localparam int DW_W = $clog2(COL_DWELL);
  localparam int CW = $clog2(NUM_COLS);
  localparam int SW = $clog2(DEBOUNCE_FRAMES+1);
  typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] image_t;
  logic [NUM_ROWS-1:0] row_s;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [CW-1:0] c_q, c_d;
  logic [NUM_COLS-1:0] col_q, col_d;
  image_t frame_q, frame_d, cand_q, cand_d, acc_q, acc_d;
  logic done_q, done_d;
  logic [SW-1:0] stable_q, stable_d;
  logic evt_valid_q, evt_valid_d, evt_release_q, evt_release_d;
  logic [IDX_W-1:0] evt_index_q, evt_index_d, held_index_q, held_index_d;
  logic key_held_q, key_held_d, multi_key_q, multi_key_d, overflow_q, overflow_d;
  logic dwell_wrap, sample, same, accept, new_evt, load, drop;
  pop_class_e old_pc, new_pc;
  logic [IDX_W-1:0] old_idx, new_idx;
  sync_2ff #(.W(NUM_ROWS), .RST_VAL({NUM_ROWS{1'b1}})) u_sync (
    .clk(clk), .rst_n(rst_n), .d(row), .q(row_s)
  );
  always_comb begin
    dwell_wrap = dwell_q == DW_W'(COL_DWELL-1);
    dwell_d = dwell_wrap ? '0 : dwell_q + 1'b1;
    c_d = dwell_wrap ? (c_q == CW'(NUM_COLS-1) ? '0 : c_q + 1'b1) : c_q;
    col_d = ~(NUM_COLS'(1) << c_d);
    sample = dwell_q == DW_W'(COL_SETTLE);
    frame_d = frame_q;
    for (int r = 0; r < NUM_ROWS; r++) if (sample) frame_d[r][c_q] = ~row_s[r];
    done_d = sample && c_q == CW'(NUM_COLS-1);
    // Debounce acts on the frame completed in the previous cycle.
    same = frame_q == cand_q;
    cand_d = done_q && !same ? frame_q : cand_q;
    stable_d = !done_q ? stable_q : !same ? SW'(1) :
               stable_q == SW'(DEBOUNCE_FRAMES) ? stable_q : stable_q + 1'b1;
    accept = done_q && stable_d == SW'(DEBOUNCE_FRAMES) && cand_d != acc_q;
    acc_d = accept ? cand_d : acc_q;
    old_pc = pop_class(MAX_KEYS'(acc_q));
    new_pc = pop_class(MAX_KEYS'(cand_d));
    old_idx = IDX_W'(onehot_idx(MAX_KEYS'(acc_q)));
    new_idx = IDX_W'(onehot_idx(MAX_KEYS'(cand_d)));
    // A single key landing reports a press; only a lone key lifting reports a release.
    new_evt = accept && (new_pc == PC_ONE || (new_pc == PC_NONE && old_pc == PC_ONE));
    load = new_evt && (!evt_valid_q || evt_ready);
    drop = new_evt && evt_valid_q && !evt_ready;
    evt_valid_d = load ? 1'b1 : evt_valid_q && evt_ready ? 1'b0 : evt_valid_q;
    evt_index_d = load ? (new_pc == PC_ONE ? new_idx : old_idx) : evt_index_q;
    evt_release_d = load ? (new_pc == PC_ONE ? EVT_PRESS : EVT_RELEASE) : evt_release_q;
    overflow_d = drop ? 1'b1 : ovf_clr ? 1'b0 : overflow_q;
    key_held_d = accept ? new_pc == PC_ONE : key_held_q;
    held_index_d = accept && new_pc == PC_ONE ? new_idx : held_index_q;
    multi_key_d = accept ? new_pc == PC_MULTI : multi_key_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dwell_q <= '0;
      c_q <= '0;
      col_q <= '1;
      frame_q <= '0;
      done_q <= 1'b0;
      cand_q <= '0;
      stable_q <= '0;
      acc_q <= '0;
      evt_valid_q <= 1'b0;
      evt_index_q <= '0;
      evt_release_q <= 1'b0;
      key_held_q <= 1'b0;
      held_index_q <= '0;
      multi_key_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dwell_q <= dwell_d;
      c_q <= c_d;
      col_q <= col_d;
      frame_q <= frame_d;
      done_q <= done_d;
      cand_q <= cand_d;
      stable_q <= stable_d;
      acc_q <= acc_d;
      evt_valid_q <= evt_valid_d;
      evt_index_q <= evt_index_d;
      evt_release_q <= evt_release_d;
      key_held_q <= key_held_d;
      held_index_q <= held_index_d;
      multi_key_q <= multi_key_d;
      overflow_q <= overflow_d;
    end
  assign col = col_q;
  assign evt_valid = evt_valid_q;
  assign evt_index = evt_index_q;
  assign evt_release = evt_release_q;
  assign key_held = key_held_q;
  assign held_index = held_index_q;
  assign multi_key = multi_key_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: randomized scenario bench with a keypad-matrix model and
// a popcount-rule event model for keypad_scanner.
module tb_keypad_scanner;
  localparam int NC = 4, NR = 4, DW = 16, CS = 8, DF = 3, NK = 16;
  localparam int FR = NC*DW, LAT = (DF+1)*FR+3;
  typedef struct {int idx; bit rel; int t;} ev_t;
  logic clk = 0, rst_n = 0, evt_ready = 1, ovf_clr = 0;
  logic [NR-1:0] row;
  logic [NC-1:0] col;
  logic evt_valid, evt_release, key_held, multi_key, overflow;
  logic [3:0] evt_index, held_index;
  logic [NK-1:0] keys = '0, acc_m = '0;
  int checks = 0, errors = 0, cyc = 0;
  ev_t evq[$];

  keypad_scanner #(.NUM_COLS(NC), .NUM_ROWS(NR), .COL_DWELL(DW), .COL_SETTLE(CS),
                   .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst_n(rst_n), .row(row), .col(col), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_index(evt_index), .evt_release(evt_release),
    .key_held(key_held), .held_index(held_index), .multi_key(multi_key),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  // Keypad matrix: a row reads low when any pressed key on it sits on a driven column.
  always_comb for (int r = 0; r < NR; r++) row[r] = ~|(keys[r*NC +: NC] & ~col);
  always @(negedge clk) if (rst_n && evt_valid && evt_ready) evq.push_back('{int'(evt_index), evt_release, cyc});

  function automatic void model_evt(input logic [NK-1:0] o, input logic [NK-1:0] n,
                                    output bit has, output int idx, output bit rel);
    int co, cn;
    co = $countones(o);
    cn = $countones(n);
    has = (o != n) && (cn == 1 || (cn == 0 && co == 1));
    rel = cn == 0;
    idx = 0;
    for (int i = 0; i < NK; i++) if (rel ? o[i] : n[i]) idx = i;
  endfunction

  task automatic drive_and_wait(input logic [NK-1:0] nk, input int budget,
                                output bit got, output ev_t e, output int lat);
    int start;
    @(posedge clk);
    #1 keys = nk;
    start = cyc;
    evq.delete();
    got = 0;
    e = '{0, 0, 0};
    lat = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (evq.size() > 0) begin
        got = 1;
        e = evq.pop_front();
        lat = e.t - start;
      end
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({col, evt_valid, evt_index, evt_release, key_held, held_index, multi_key, overflow} !== {4'hF, 13'b0}) begin
      errors++;
      $display("FAIL reset_state got %b want %b", {col, evt_valid, evt_index, evt_release, key_held, held_index, multi_key, overflow}, {4'hF, 13'b0});
    end
    rst_n = 1;
    for (int n = 1; n <= 4*FR; n++) begin
      @(negedge clk);
      exp = ~(4'b1 << ((n/DW) % NC));
      checks++;
      if (col !== exp) begin
        errors++;
        $display("FAIL scan_col cycle %0d got %b want %b", n, col, exp);
      end
    end
    checks++;
    if ({evt_valid, key_held, multi_key, overflow} !== 4'b0) begin
      errors++;
      $display("FAIL idle_status got %b want 0000", {evt_valid, key_held, multi_key, overflow});
    end
    acc_m = '0;
  endtask

  task automatic test_press_release;
    logic [NK-1:0] nk;
    bit has, rel, got;
    int idx, lat;
    ev_t e;
    for (int it = 0; it < 3; it++) begin
      nk = NK'(1) << (it == 0 ? 6 : $urandom_range(0, NK-1));
      for (int ph = 0; ph < 2; ph++) begin
        if (ph == 1) nk = '0;
        model_evt(acc_m, nk, has, idx, rel);
        drive_and_wait(nk, LAT+5, got, e, lat);
        checks++;
        if (got !== has || e.idx != idx || e.rel !== rel || lat > LAT) begin
          errors++;
          $display("FAIL press_release_evt got v=%0b idx=%0d rel=%0b lat=%0d want v=%0b idx=%0d rel=%0b lat<=%0d", got, e.idx, e.rel, lat, has, idx, rel, LAT);
        end
        checks++;
        if (key_held !== (ph == 0) || (ph == 0 && held_index !== 4'(idx)) || multi_key !== 1'b0) begin
          errors++;
          $display("FAIL press_release_status got held=%0b hidx=%0d multi=%0b want held=%0b hidx=%0d multi=0", key_held, held_index, multi_key, ph == 0, idx);
        end
        acc_m = nk;
        repeat (2*FR) @(negedge clk);
        checks++;
        if (evq.size() != 0) begin
          errors++;
          $display("FAIL press_release_extra got %0d extra events want 0", evq.size());
        end
      end
    end
  endtask

  task automatic test_bounce;
    logic [NK-1:0] nk;
    bit has, rel, got;
    int idx, lat;
    ev_t e;
    nk = NK'(1) << $urandom_range(0, NK-1);
    evq.delete();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 keys = i[0] ? '0 : nk;
      repeat (FR-1) @(posedge clk);
    end
    checks++;
    if (evq.size() != 0 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL bounce_spurious got %0d events held=%0b want 0 events held=0", evq.size(), key_held);
    end
    model_evt(acc_m, nk, has, idx, rel);
    drive_and_wait(nk, LAT+5, got, e, lat);
    repeat (2*FR) @(negedge clk);
    checks++;
    if (!got || e.idx != idx || e.rel !== rel || evq.size() != 0) begin
      errors++;
      $display("FAIL bounce_single got v=%0b idx=%0d rel=%0b extra=%0d want v=1 idx=%0d rel=%0b extra=0", got, e.idx, e.rel, evq.size(), idx, rel);
    end
    acc_m = nk;
    model_evt(acc_m, '0, has, idx, rel);
    drive_and_wait('0, LAT+5, got, e, lat);
    checks++;
    if (!got || e.idx != idx || e.rel !== rel) begin
      errors++;
      $display("FAIL bounce_release got v=%0b idx=%0d rel=%0b want v=1 idx=%0d rel=%0b", got, e.idx, e.rel, idx, rel);
    end
    acc_m = '0;
  endtask

  task automatic test_multi;
    int a, b, idx, lat;
    bit has, rel, got;
    ev_t e;
    for (int it = 0; it < 2; it++) begin
      a = it == 0 ? 0 : $urandom_range(0, NK-1);
      b = it == 0 ? 5 : (a + 1 + $urandom_range(0, NK-2)) % NK;
      drive_and_wait((NK'(1) << a) | (NK'(1) << b), LAT+FR, got, e, lat);
      checks++;
      if (got || multi_key !== 1'b1 || key_held !== 1'b0) begin
        errors++;
        $display("FAIL multi_two got evt=%0b multi=%0b held=%0b want evt=0 multi=1 held=0", got, multi_key, key_held);
      end
      acc_m = (NK'(1) << a) | (NK'(1) << b);
      model_evt(acc_m, NK'(1) << b, has, idx, rel);
      drive_and_wait(NK'(1) << b, LAT+5, got, e, lat);
      checks++;
      if (got !== has || e.idx != idx || e.rel !== rel || multi_key !== 1'b0 || key_held !== 1'b1 || held_index !== 4'(b)) begin
        errors++;
        $display("FAIL multi_to_one got v=%0b idx=%0d rel=%0b multi=%0b held=%0b hidx=%0d want v=%0b idx=%0d rel=%0b multi=0 held=1 hidx=%0d", got, e.idx, e.rel, multi_key, key_held, held_index, has, idx, rel, b);
      end
      acc_m = NK'(1) << b;
      model_evt(acc_m, '0, has, idx, rel);
      drive_and_wait('0, LAT+5, got, e, lat);
      checks++;
      if (!got || e.idx != idx || e.rel !== rel || key_held !== 1'b0) begin
        errors++;
        $display("FAIL multi_release got v=%0b idx=%0d rel=%0b held=%0b want v=1 idx=%0d rel=%0b held=0", got, e.idx, e.rel, key_held, idx, rel);
      end
      acc_m = '0;
    end
  endtask

  task automatic test_overflow;
    bit got;
    @(posedge clk);
    #1 evt_ready = 0;
    keys = NK'(1) << 3;
    got = 0;
    for (int i = 0; i < LAT+5 && !got; i++) begin
      @(negedge clk);
      got = evt_valid;
    end
    checks++;
    if (!got || evt_index !== 4'd3 || evt_release !== 1'b0) begin
      errors++;
      $display("FAIL ovf_first got v=%0b idx=%0d rel=%0b want v=1 idx=3 rel=0", got, evt_index, evt_release);
    end
    @(posedge clk);
    #1 keys = '0;
    repeat (LAT+FR) @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_index !== 4'd3 || evt_release !== 1'b0 || overflow !== 1'b1 || key_held !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop got v=%0b idx=%0d rel=%0b ovf=%0b held=%0b want v=1 idx=3 rel=0 ovf=1 held=0", evt_valid, evt_index, evt_release, overflow, key_held);
    end
    @(posedge clk);
    #1 ovf_clr = 1;
    @(posedge clk);
    #1 ovf_clr = 0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0 || evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear got ovf=%0b v=%0b want ovf=0 v=1", overflow, evt_valid);
    end
    @(posedge clk);
    #1 evt_ready = 1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain got v=%0b want v=0", evt_valid);
    end
    evq.delete();
    acc_m = '0;
  endtask

  task automatic test_reset_mid;
    logic [NK-1:0] nk;
    int k, idx, lat;
    bit has, rel, got;
    ev_t e;
    k = $urandom_range(0, NK-1);
    nk = NK'(1) << k;
    drive_and_wait(nk, LAT+5, got, e, lat);
    checks++;
    if (!got || e.idx != k || key_held !== 1'b1) begin
      errors++;
      $display("FAIL rmid_press got v=%0b idx=%0d held=%0b want v=1 idx=%0d held=1", got, e.idx, key_held, k);
    end
    repeat ($urandom_range(1, 40)) @(posedge clk);
    #3 rst_n = 0;
    #1;
    checks++;
    if ({col, evt_valid, evt_index, evt_release, key_held, held_index, multi_key, overflow} !== {4'hF, 13'b0}) begin
      errors++;
      $display("FAIL rmid_async got %b want %b", {col, evt_valid, evt_index, evt_release, key_held, held_index, multi_key, overflow}, {4'hF, 13'b0});
    end
    @(negedge clk);
    rst_n = 1;
    evq.delete();
    acc_m = '0;
    @(negedge clk);
    checks++;
    if (col !== 4'b1110) begin
      errors++;
      $display("FAIL rmid_col0 got %b want 1110", col);
    end
    model_evt(acc_m, nk, has, idx, rel);
    got = 0;
    for (int i = 0; i < LAT+5 && !got; i++) begin
      @(negedge clk);
      if (evq.size() > 0) begin
        got = 1;
        e = evq.pop_front();
      end
    end
    checks++;
    if (!got || e.idx != idx || e.rel !== rel || key_held !== 1'b1 || held_index !== 4'(k)) begin
      errors++;
      $display("FAIL rmid_redebounce got v=%0b idx=%0d rel=%0b held=%0b hidx=%0d want v=1 idx=%0d rel=%0b held=1 hidx=%0d", got, e.idx, e.rel, key_held, held_index, idx, rel, k);
    end
    acc_m = nk;
    model_evt(acc_m, '0, has, idx, rel);
    drive_and_wait('0, LAT+5, got, e, lat);
    checks++;
    if (!got || e.idx != idx || e.rel !== rel) begin
      errors++;
      $display("FAIL rmid_release got v=%0b idx=%0d rel=%0b want v=1 idx=%0d rel=%0b", got, e.idx, e.rel, idx, rel);
    end
    acc_m = '0;
  endtask

  initial begin
    test_reset;
    test_press_release;
    test_bounce;
    test_multi;
    test_overflow;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
